// File: rtl/bit_scan_pkg.sv
// Shared constants, state type and helpers for the bit-scan encoder.
// Imported by lsb_enc_32 and bit_scan_enc.
package bit_scan_pkg;

  localparam int W  = 32;
  localparam int IW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when vec has zero or one bit set.
  function automatic logic onehot_or_zero(
    input logic [W-1:0] vec
  );
    return (vec & (vec - W'(1))) == '0;
  endfunction

endpackage

// File: rtl/lsb_enc_32.sv
// Combinational lowest-set-bit encoder.
// Ports: vec in; idx = position of lowest 1 (0 if none), any = |vec.
module lsb_enc_32
  import bit_scan_pkg::*;
(
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[IW-1:0];
    end
  end

  assign any = |vec;

endmodule

// File: rtl/bit_scan_enc.sv
// Sequential 32-to-5 encoder: one index per beat, lowest set bit first.
// Ports: clk, rst_n, en; in_valid/in_ready/in_vec; out_* beat outputs.
module bit_scan_enc
  import bit_scan_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_none,
  output logic [IW-1:0] out_seq
);

  state_t         state, state_n;
  logic [W-1:0]   pend, pend_n;
  logic           zero_flag, zero_n;
  logic [IW-1:0]  seq, seq_n;

  logic [IW-1:0]  lsb_idx;
  logic           lsb_any;
  logic           emit;
  logic           accept;
  logic           xfer;

  lsb_enc_32 u_lsb (
    .vec (pend),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  // Outputs are forced low while reset is held.
  assign emit = rst_n && (state == EMIT);

  assign out_valid = emit && en;
  assign out_last  = emit && onehot_or_zero(pend);
  assign out_none  = emit && zero_flag;
  assign out_idx   = (emit && lsb_any) ? lsb_idx : '0;
  assign out_seq   = emit ? seq : '0;

  // In EMIT, a new vector may slot in behind the final beat.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && en) begin
      if (state == IDLE) in_ready = 1'b1;
      else               in_ready = out_ready && out_last;
    end
  end

  assign accept = en && in_valid && in_ready;
  assign xfer   = en && out_valid && out_ready;

  always_comb begin
    state_n = state;
    pend_n  = pend;
    zero_n  = zero_flag;
    seq_n   = seq;
    if (xfer && !out_last) begin
      pend_n = pend & ~(W'(1) << out_idx);
      seq_n  = seq + IW'(1);
    end else if (accept) begin
      state_n = EMIT;
      pend_n  = in_vec;
      zero_n  = (in_vec == '0);
      seq_n   = '0;
    end else if (xfer) begin
      state_n = IDLE;
      pend_n  = '0;
      zero_n  = 1'b0;
      seq_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      zero_flag <= 1'b0;
      seq       <= '0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      zero_flag <= zero_n;
      seq       <= seq_n;
    end
  end

endmodule

// File: tb/tb_bit_scan_enc.sv
// Directed self-checking bench for bit_scan_enc.
// Drives and samples on the falling edge.
module tb_bit_scan_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        out_none;
  logic [4:0]  out_seq;

  int nchk = 0;
  int nerr = 0;

  // {valid, idx, last, none, seq}
  logic [12:0] obs;
  assign obs = {out_valid, out_idx, out_last, out_none, out_seq};

  always #5 clk = ~clk;

  bit_scan_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_seq   (out_seq)
  );

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0;
    in_vec = 32'hDEAD_BEEF; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      nchk++;
      if (obs !== 13'h0 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL reset_hold: obs=%h rdy=%b want 0 0",
                 obs, in_ready);
      end
    end
    rst_n = 1'b1;
    #1;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_release: v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_multi();
    logic [4:0] ei [3] = '{5'd0, 5'd4, 5'd31};
    logic       el [3] = '{1'b0, 1'b0, 1'b1};
    logic [12:0] exp;
    @(negedge clk);
    in_vec = 32'h8000_0011; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_vec = 32'hFFFF_0000;
      exp = {1'b1, ei[i], el[i], 1'b0, 5'(i)};
      nchk++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL multi_beat%0d: got %h want %h", i, obs, exp);
      end
    end
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL multi_idle: v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_zero();
    in_vec = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nchk++;
    if (obs !== {1'b1, 5'd0, 1'b1, 1'b1, 5'd0}) begin
      nerr++;
      $display("FAIL zero_beat: got %h want %h", obs,
               {1'b1, 5'd0, 1'b1, 1'b1, 5'd0});
    end
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL zero_idle: v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    in_vec = 32'h6; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      nchk++;
      if (obs !== {1'b1, 5'd1, 1'b0, 1'b0, 5'd0} || in_ready) begin
        nerr++;
        $display("FAIL stall%0d: got %h rdy=%b want %h 0", i, obs,
                 in_ready, {1'b1, 5'd1, 1'b0, 1'b0, 5'd0});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_vec = 32'h1; in_valid = 1'b1;
    #1;
    nchk++;
    if (obs !== {1'b1, 5'd2, 1'b1, 1'b0, 5'd1} || !in_ready) begin
      nerr++;
      $display("FAIL b2b_last: got %h rdy=%b want %h 1", obs,
               in_ready, {1'b1, 5'd2, 1'b1, 1'b0, 5'd1});
    end
    @(negedge clk);
    in_valid = 1'b0;
    nchk++;
    if (obs !== {1'b1, 5'd0, 1'b1, 1'b0, 5'd0}) begin
      nerr++;
      $display("FAIL b2b_next: got %h want %h", obs,
               {1'b1, 5'd0, 1'b1, 1'b0, 5'd0});
    end
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_idle: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_en_gap();
    logic [12:0] exp;
    in_vec = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = {1'b1, 5'(i), (i == 31), 1'b0, 5'(i)};
      nchk++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL all_beat%0d: got %h want %h", i, obs, exp);
      end
      if (i == 10) begin
        en = 1'b0;
        repeat (2) begin
          @(negedge clk);
          nchk++;
          if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL en_low: v=%b rdy=%b want 0 0",
                     out_valid, in_ready);
          end
        end
        en = 1'b1;
        #1;
        nchk++;
        if (obs !== exp) begin
          nerr++;
          $display("FAIL en_resume: got %h want %h", obs, exp);
        end
      end
    end
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL all_idle: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    in_vec = 32'hF0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nchk++;
    if (obs !== {1'b1, 5'd4, 1'b0, 1'b0, 5'd0}) begin
      nerr++;
      $display("FAIL mid_first: got %h want %h", obs,
               {1'b1, 5'd4, 1'b0, 1'b0, 5'd0});
    end
    rst_n = 1'b0;
    @(negedge clk);
    nchk++;
    if (obs !== 13'h0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL mid_rst: got %h rdy=%b want 0 0", obs, in_ready);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nchk++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL mid_stale: v=%b idx=%0d want v=0",
                 out_valid, out_idx);
      end
    end
    in_vec = 32'h2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nchk++;
    if (obs !== {1'b1, 5'd1, 1'b1, 1'b0, 5'd0}) begin
      nerr++;
      $display("FAIL mid_next: got %h want %h", obs,
               {1'b1, 5'd1, 1'b1, 1'b0, 5'd0});
    end
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_idle: v=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_multi();
    test_zero();
    test_back_to_back();
    test_en_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bit_scan_enc.md
Name: bit_scan_enc

Overview:
- Sequential 32-to-5 encoder; the inverse direction of the team's 5-to-32 one-hot decoder.
- Accepts a 32-bit request vector over a valid/ready handshake.
- Emits the 5-bit index of every set bit, lowest first, one index per beat over a second valid/ready handshake.
- Sits between request-collection logic and any consumer that needs bit positions, e.g. re-driving the decoder.

Parameters:
- W, 32, input vector width (power of two).
- IW, 5, index width, equal to log2(W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  global enable; when low, no handshake completes and all state holds.
- in_valid  input  1  in_vec is offered.
- in_ready  output  1  block can accept in_vec this cycle.
- in_vec  input  W  request vector; multi-hot allowed.
- out_valid  output  1  out_idx/out_last/out_none/out_seq are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IW  index of the lowest pending set bit.
- out_last  output  1  this beat is the final one for the current vector.
- out_none  output  1  the accepted vector was all-zero; a single dummy beat.
- out_seq  output  IW  ordinal of this beat within the vector, starting at 0.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low; rst_n sampled low at a rising edge resets the block.
- Reset values:
  - state=IDLE, pend=0, out_seq=0, zero_flag=0.
  - out_valid=0, out_idx=0, out_last=0, out_none=0.
  - in_ready=0 while rst_n is low.
- Registers: pend[W-1:0], zero_flag, state {IDLE, EMIT}, seq counter.
- Input accept: accept = en & in_valid & in_ready.
- Output transfer: xfer = en & out_valid & out_ready.
- IDLE:
  - in_ready = en; out_valid = 0.
  - On accept: pend <= in_vec, zero_flag <= (in_vec == 0), seq <= 0, next state EMIT.
- EMIT:
  - out_valid = en.
  - out_idx = position of the least-significant 1 in pend, or 0 when zero_flag is set.
  - out_last = 1 when pend has at most one set bit.
  - out_none = zero_flag.
  - out_seq = seq.
- On xfer, not last: clear bit out_idx in pend; seq <= seq+1; remain in EMIT.
- On xfer with out_last:
  - If accept occurs in the same cycle, load the new vector and stay in EMIT (back-to-back).
  - Otherwise clear pend, zero_flag and seq, and go to IDLE.
- in_ready in EMIT = en & out_ready & out_last.
  - This is a combinational out_ready-to-in_ready path and is permitted.
- Latency and throughput:
  - First out_valid comes the cycle after accept.
  - Throughput is one index per cycle while out_ready=1.
  - A vector with k set bits occupies k beats; an all-zero vector occupies 1 beat.
- Outputs are stable while out_valid=1 and out_ready=0.
- en low: all registers hold, in_ready=0, out_valid=0; processing resumes unchanged when en returns high.
- Index range: all 32 ones produces 32 beats, idx 0..31 and seq 0..31; seq never exceeds W-1, so no wrap.
- Reset mid-operation returns to the reset values the next edge; the pending vector is discarded without any further beat.
- in_vec is ignored when no accept occurs.

Decomposition:
- Package bit_scan_pkg:
  - W and IW constants.
  - State typedef {IDLE, EMIT}.
  - Function onehot_or_zero(vec), returning 1 when vec has at most one set bit.
- Sub-module lsb_enc_32, purely combinational:
  - Inputs: vec[W-1:0].
  - Outputs: idx[IW-1:0] (position of the lowest set bit) and any (vec != 0).
  - Instantiated once on pend.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> out_valid=0, in_ready=1; all outputs 0 during reset.
- in_vec=32'h8000_0011, out_ready=1 -> beats idx 0,4,31; seq 0,1,2; out_last only on idx 31; out_none=0; first beat the cycle after accept.
- in_vec=0 -> one beat: idx=0, out_none=1, out_last=1, then return to IDLE.
- in_vec=32'h0000_0006 with out_ready low for 3 cycles -> idx=1 held stable with out_valid=1; then idx 1, idx 2; second vector 32'h1 offered during the last beat is accepted back-to-back and yields idx 0 the next cycle.
- in_vec=32'hFFFF_FFFF with en dropped for 2 cycles mid-stream -> 32 beats idx 0..31 in order; no beat lost or duplicated across the en gap.
- Accept 32'hF0, assert rst_n=0 after the first beat -> after reset out_valid=0, no idx 5/6/7 emitted, and the next vector 32'h2 yields a single beat idx 1.
